// File: rtl/i2s_pkg.sv
// Shared types and sizing helpers for the I2S transmit path.
package i2s_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_SLOT_W = 32;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_e;

    function automatic int unsigned bit_cnt_w(input int unsigned slot_w);
        return $clog2(2 * slot_w);
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK generator: divides clk by BCLK_DIV into a registered 50% duty bit clock and
// flags the clk cycle that precedes each BCLK falling edge.
module i2s_bclk_gen #(
    parameter int unsigned BCLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    output logic o_bclk,
    output logic o_fall_tick
);

    localparam int unsigned     DIV_W   = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] RISE_AT = DIV_W'(BCLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FALL_AT = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic             w_rise_tick;
    logic             w_fall_tick;

    assign w_rise_tick = (r_div_cnt == RISE_AT);
    assign w_fall_tick = (r_div_cnt == FALL_AT);
    assign o_bclk      = r_bclk;
    assign o_fall_tick = w_fall_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_fall_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_rise_tick) begin
                r_bclk <= 1'b1;
            end else if (w_fall_tick) begin
                r_bclk <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_ser.sv
// Philips I2S transmit serializer with a one-pair holding buffer.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module i2s_tx_ser
    import i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 8,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned SLOT_W   = DEF_SLOT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bclk,
    output logic              lrck,
    output logic              sdata,
    output logic              underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int unsigned       FRAME_W  = 2 * SLOT_W;
    localparam int unsigned       CNT_W    = bit_cnt_w(SLOT_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  R_FIRST  = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0]  R_LAST   = CNT_W'(FRAME_W - 2);

    logic                r_full;
    logic [DATA_W-1:0]   r_buf_l;
    logic [DATA_W-1:0]   r_buf_r;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [FRAME_W-1:0]  r_shift;
    chan_e               r_lrck;
    logic                r_sdata;
    logic                r_underrun;

    logic                w_fall_tick;
    logic                w_frame_load;
    logic                w_xfer;
    logic                w_underrun_set;
    logic [CNT_W-1:0]    w_bit_nxt;
    chan_e               w_lrck_nxt;
    logic [FRAME_W-1:0]  w_load_word;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk         (clk),
        .rst         (rst),
        .o_bclk      (bclk),
        .o_fall_tick (w_fall_tick)
    );

    assign w_bit_nxt      = (r_bit_cnt == CNT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
    assign w_frame_load   = w_fall_tick && (r_bit_cnt == CNT_LAST);
    assign w_xfer         = in_valid && !r_full;
    assign w_underrun_set = w_frame_load && !r_full;
    // One-bit I2S delay: LRCK flips on the last bit of the preceding slot.
    assign w_lrck_nxt     = ((w_bit_nxt >= R_FIRST) && (w_bit_nxt <= R_LAST)) ? RIGHT : LEFT;

    // Each channel is MSB-aligned in its slot; the slot tail is zero padding.
    always_comb begin
        w_load_word = '0;
        if (r_full) begin
            w_load_word[FRAME_W-1 -: DATA_W] = r_buf_l;
            w_load_word[SLOT_W-1 -: DATA_W]  = r_buf_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 1'b0;
            r_buf_l   <= '0;
            r_buf_r   <= '0;
        end else if (w_xfer) begin
            r_full    <= 1'b1;
            r_buf_l   <= in_left;
            r_buf_r   <= in_right;
        end else if (w_frame_load) begin
            r_full    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= CNT_LAST;
            r_shift    <= '0;
            r_lrck     <= LEFT;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_underrun_set;
            if (w_fall_tick) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrck    <= w_lrck_nxt;
                if (w_frame_load) begin
                    r_sdata <= w_load_word[FRAME_W-1];
                    r_shift <= {w_load_word[FRAME_W-2:0], 1'b0};
                end else begin
                    r_sdata <= r_shift[FRAME_W-1];
                    r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] r_urun_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_urun_cnt <= '0;
        end else if (w_underrun_set && (r_urun_cnt != 16'hFFFF)) begin
            r_urun_cnt <= r_urun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_urun_cnt;
`endif

    assign in_ready = !r_full;
    assign lrck     = r_lrck;
    assign sdata    = r_sdata;
    assign underrun = r_underrun;

endmodule
